// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: resolved opcodes,
// FSM state encoding and the default address width.
package fetch_pkg;

  localparam int DEFAULT_ADDR_W = 8;

  localparam logic [7:0] OP_JMP  = 8'h81;
  localparam logic [7:0] OP_CALL = 8'h82;
  localparam logic [7:0] OP_RET  = 8'h83;
  localparam logic [7:0] OP_GOTO = 8'h84;
  localparam logic [7:0] OP_JZ   = 8'h85;
  localparam logic [7:0] OP_JNZ  = 8'h87;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    ISSUE  = 3'd2,
    TARGET = 3'd3,
    RETURN = 3'd4
  } fetch_state_t;

  // Opcodes that take an operand byte and are resolved without the control unit.
  function automatic logic takes_operand(input logic [7:0] op);
    return (op == OP_JMP) || (op == OP_CALL) || (op == OP_GOTO) ||
           (op == OP_JZ)  || (op == OP_JNZ);
  endfunction

endpackage

// File: rtl/fetch_unit_return_stack.sv
// Return-address LIFO. dout always shows the top entry; push on full and
// pop on empty leave the pointer untouched.
module return_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W:0] SP_ONE  = (IDX_W+1)'(1);
  localparam logic [IDX_W:0] SP_FULL = (IDX_W+1)'(DEPTH);

  logic [W-1:0]   mem [DEPTH];
  logic [IDX_W:0] sp;
  logic [IDX_W:0] sp_m1;

  assign sp_m1 = sp - SP_ONE;
  assign dout  = mem[sp_m1[IDX_W-1:0]];
  assign full  = (sp == SP_FULL);
  assign empty = (sp == '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + SP_ONE;
    end else if (pop && !empty) begin
      sp <= sp_m1;
    end
  end

  always_ff @(posedge clock) begin
    if (push && !full) begin
      mem[sp[IDX_W-1:0]] <= din;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches opcodes, resolves control flow
// locally and hands only ALU-class opcodes to the control unit.
// Handshakes: a memory read completes on any cycle with imem_req && imem_valid;
// imem_addr is held while imem_req is high. An ISSUE opcode completes on
// ir_valid && pc_load; pc_load is ignored whenever ir_valid is low.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W      = DEFAULT_ADDR_W,
  parameter int                STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              pc_load,
  input  logic              zero_flag,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_valid,
  input  logic [7:0]        imem_data,
  output logic [7:0]        ir,
  output logic              ir_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              stack_err,
  output fetch_state_t      state
);

  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        ir_q, ir_d;
  logic              err_q, err_d;
  logic              push, pop, taken;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] stack_top;
  logic              stack_full, stack_empty;

  assign pc_inc    = pc_q + PC_ONE;
  assign pc        = pc_q;
  assign ir        = ir_q;
  assign stack_err = err_q;
  assign state     = state_q;

  return_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (ADDR_W)
  ) u_stack (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .din     (pc_inc),
    .dout    (stack_top),
    .full    (stack_full),
    .empty   (stack_empty)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    err_d     = err_q;
    push      = 1'b0;
    pop       = 1'b0;
    taken     = 1'b0;
    imem_req  = 1'b0;
    imem_addr = '0;
    ir_valid  = 1'b0;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        imem_req  = 1'b1;
        imem_addr = pc_q;
        if (imem_valid) begin
          ir_d = imem_data;
          if (imem_data == OP_RET) begin
            state_d = RETURN;
          end else if (takes_operand(imem_data)) begin
            pc_d    = pc_inc;
            state_d = TARGET;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        ir_valid = 1'b1;
        if (pc_load) begin
          pc_d    = pc_inc;
          state_d = FETCH;
        end
      end
      TARGET: begin
        imem_req  = 1'b1;
        imem_addr = pc_q;
        if (imem_valid) begin
          case (ir_q)
            OP_JMP, OP_GOTO: taken = 1'b1;
            OP_JZ:           taken = zero_flag;
            OP_JNZ:          taken = !zero_flag;
            OP_CALL: begin
              // A CALL that cannot save its return address falls through.
              if (stack_full) begin
                err_d = 1'b1;
              end else begin
                taken = 1'b1;
                push  = 1'b1;
              end
            end
            default: taken = 1'b0;
          endcase
          pc_d    = taken ? ADDR_W'(imem_data) : pc_inc;
          state_d = FETCH;
        end
      end
      RETURN: begin
        if (stack_empty) begin
          pc_d  = pc_inc;
          err_d = 1'b1;
        end else begin
          pc_d = stack_top;
          pop  = 1'b1;
        end
        state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a byte-array instruction memory with a
// programmable response delay, and cycle-exact expected fetch addresses.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic         clock;
  logic         reset_n;
  logic         pc_load;
  logic         zero_flag;
  logic         imem_req;
  logic [7:0]   imem_addr;
  logic         imem_valid;
  logic [7:0]   imem_data;
  logic [7:0]   ir;
  logic         ir_valid;
  logic [7:0]   pc;
  logic         stack_err;
  fetch_state_t state;

  logic [7:0] mem [256];
  int         delay;
  int         wait_cnt;
  int         n_cmp;
  int         n_err;

  fetch_unit #(.ADDR_W(8), .STACK_DEPTH(4), .RESET_PC(8'h00)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .pc_load    (pc_load),
    .zero_flag  (zero_flag),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_valid (imem_valid),
    .imem_data  (imem_data),
    .ir         (ir),
    .ir_valid   (ir_valid),
    .pc         (pc),
    .stack_err  (stack_err),
    .state      (state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // memory model: answers once the request has waited 'delay' cycles
  assign imem_data  = mem[imem_addr];
  assign imem_valid = imem_req && (wait_cnt >= delay);

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) wait_cnt <= 0;
    else if (imem_req && !imem_valid) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mem;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  task automatic do_reset;
    reset_n   = 1'b0;
    pc_load   = 1'b0;
    zero_flag = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic expect_fetch(input string tag, input logic [7:0] a);
    chk({tag, " req"}, imem_req, 1);
    chk({tag, " addr"}, imem_addr, a);
    chk({tag, " ir_valid"}, ir_valid, 0);
  endtask

  // two-byte resolved opcode at a: opcode fetch then operand fetch
  task automatic branch(input string tag, input logic [7:0] a);
    logic [7:0] nxt;
    nxt = a + 8'd1;
    expect_fetch(tag, a);
    tick;
    expect_fetch({tag, " opnd"}, nxt);
    tick;
  endtask

  task automatic ret(input string tag, input logic [7:0] a);
    expect_fetch(tag, a);
    tick;
    chk({tag, " idle req"}, imem_req, 0);
    chk({tag, " ir_valid"}, ir_valid, 0);
    tick;
  endtask

  // driver / directed sequence
  initial begin
    n_cmp   = 0;
    n_err   = 0;
    delay   = 0;
    reset_n = 1'b0;
    pc_load = 1'b0;
    zero_flag = 1'b0;

    // ---- ALU issue, jumps, JZ both ways, CALL/RET ----
    clear_mem;
    mem[8'h00] = 8'h01; mem[8'h01] = 8'h81; mem[8'h02] = 8'h10;
    mem[8'h10] = 8'h81; mem[8'h11] = 8'h40;
    mem[8'h40] = 8'h81; mem[8'h41] = 8'h30;
    mem[8'h30] = 8'h85; mem[8'h31] = 8'h20;
    mem[8'h20] = 8'h81; mem[8'h21] = 8'h30;
    mem[8'h32] = 8'h81; mem[8'h33] = 8'h05;
    mem[8'h05] = 8'h82; mem[8'h06] = 8'h50;
    mem[8'h50] = 8'h83; mem[8'h07] = 8'h01;
    do_reset;
    chk("rst pc", pc, 8'h00);
    chk("rst ir", ir, 8'h00);
    chk("rst ir_valid", ir_valid, 0);
    chk("rst req", imem_req, 0);
    chk("rst addr", imem_addr, 8'h00);
    chk("rst stack_err", stack_err, 0);
    tick;
    expect_fetch("fetch0", 8'h00);
    tick;
    chk("issue ir", ir, 8'h01);
    chk("issue ir_valid", ir_valid, 1);
    chk("issue pc", pc, 8'h00);
    chk("issue req", imem_req, 0);
    pc_load = 1'b1;
    tick;
    pc_load = 1'b0;
    chk("pc_load pc", pc, 8'h01);
    branch("jmp@01", 8'h01);
    branch("jmp@10", 8'h10);
    branch("jmp@40", 8'h40);
    zero_flag = 1'b1;
    branch("jz taken", 8'h30);
    chk("jz taken pc", pc, 8'h20);
    zero_flag = 1'b0;
    branch("jmp@20", 8'h20);
    branch("jz not taken", 8'h30);
    chk("jz not taken pc", pc, 8'h32);
    branch("jmp@32", 8'h32);
    branch("call@05", 8'h05);
    chk("call pc", pc, 8'h50);
    ret("ret@50", 8'h50);
    chk("ret pc", pc, 8'h07);
    expect_fetch("after ret", 8'h07);
    tick;
    chk("after ret ir_valid", ir_valid, 1);
    chk("after ret ir", ir, 8'h01);
    chk("after ret stack_err", stack_err, 0);

    // ---- stack overflow and underflow ----
    clear_mem;
    mem[8'h00] = 8'h81; mem[8'h01] = 8'h60;
    mem[8'h60] = 8'h82; mem[8'h61] = 8'h70;
    mem[8'h70] = 8'h82; mem[8'h71] = 8'h80;
    mem[8'h80] = 8'h82; mem[8'h81] = 8'h90;
    mem[8'h90] = 8'h82; mem[8'h91] = 8'hA0;
    mem[8'hA0] = 8'h82; mem[8'hA1] = 8'hB0;
    mem[8'hA2] = 8'h83; mem[8'h92] = 8'h83; mem[8'h82] = 8'h83;
    mem[8'h72] = 8'h83; mem[8'h62] = 8'h83; mem[8'h63] = 8'h01;
    do_reset;
    tick;
    branch("s2 jmp", 8'h00);
    branch("call1", 8'h60);
    branch("call2", 8'h70);
    branch("call3", 8'h80);
    branch("call4", 8'h90);
    chk("four calls stack_err", stack_err, 0);
    branch("call5 full", 8'hA0);
    chk("call full pc", pc, 8'hA2);
    chk("call full stack_err", stack_err, 1);
    ret("ret4", 8'hA2);
    ret("ret3", 8'h92);
    ret("ret2", 8'h82);
    ret("ret1", 8'h72);
    ret("ret empty", 8'h62);
    chk("ret empty pc", pc, 8'h63);
    chk("ret empty stack_err", stack_err, 1);
    expect_fetch("after underflow", 8'h63);
    tick;
    chk("underflow issue", ir_valid, 1);

    // ---- wait states and asynchronous reset mid-read ----
    clear_mem;
    mem[8'h00] = 8'h01;
    delay = 3;
    do_reset;
    tick;
    expect_fetch("wait c0", 8'h00);
    tick;
    expect_fetch("wait c1", 8'h00);
    tick;
    reset_n = 1'b0;
    #1;
    chk("async rst req", imem_req, 0);
    chk("async rst addr", imem_addr, 8'h00);
    chk("async rst ir_valid", ir_valid, 0);
    chk("async rst state", state, IDLE);
    reset_n = 1'b1;
    tick;
    expect_fetch("restart c0", 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick;
      expect_fetch("restart wait", 8'h00);
    end
    tick;
    chk("delayed issue ir_valid", ir_valid, 1);
    chk("delayed issue ir", ir, 8'h01);
    chk("delayed issue stack_err", stack_err, 0);

    // ---- pc_load ignored outside ISSUE, PC wrap ----
    clear_mem;
    mem[8'h00] = 8'h81; mem[8'h01] = 8'hFF; mem[8'hFF] = 8'h01;
    delay = 0;
    do_reset;
    tick;
    pc_load = 1'b1;
    branch("ld ignored jmp", 8'h00);
    pc_load = 1'b0;
    chk("ld ignored pc", pc, 8'hFF);
    expect_fetch("fetch ff", 8'hFF);
    tick;
    chk("wrap issue pc", pc, 8'hFF);
    chk("wrap issue ir_valid", ir_valid, 1);
    pc_load = 1'b1;
    tick;
    pc_load = 1'b0;
    chk("wrap pc", pc, 8'h00);
    expect_fetch("wrap fetch", 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch and control-flow stage sitting directly upstream of the control unit. It owns the program counter, fetches opcode bytes from instruction memory through a request/valid handshake, and presents the IR to the control unit. It resolves all control-flow opcodes (JMP, CALL, RET, GOTO, JZ, JNZ) internally using an operand-byte fetch, the ALU zero flag and a small return-address stack. Only ALU/MOV/CMP/shift opcodes are handed to the control unit.

## Interface
- ADDR_W, 8, PC / memory address width.
- STACK_DEPTH, 4, return-address stack entries (power of two, ≥2).
- RESET_PC, 0, PC value after reset.

Ports:
- clock  in  1  single clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- pc_load  in  1  control-unit strobe: current IR consumed, advance PC.
- zero_flag  in  1  ALU zero flag, used by JZ/JNZ.
- imem_req  out  1  memory read request.
- imem_addr  out  ADDR_W  read address; stable while imem_req is high.
- imem_valid  in  1  read data valid; meaningful only while imem_req is high.
- imem_data  in  8  read data byte.
- ir  out  8  current instruction opcode to the control unit.
- ir_valid  out  1  ir holds a non-control-flow opcode awaiting pc_load.
- pc  out  ADDR_W  current program counter.
- stack_err  out  1  sticky: CALL on full stack or RET on empty stack.

## Operation
- Opcodes resolved here: 0x81 JMP, 0x82 CALL, 0x83 RET, 0x84 GOTO, 0x85 JZ, 0x87 JNZ. All other bytes go to the control unit.
- States: IDLE, FETCH, ISSUE, TARGET, RETURN.
- IDLE: entered on reset; goes to FETCH after one cycle.
- FETCH: imem_req=1, imem_addr=pc. On the accept cycle (imem_req && imem_valid), ir<=imem_data.
  - RET: go to RETURN.
  - Other resolved opcodes: pc<=pc+1, go to TARGET.
  - Anything else: go to ISSUE.
- ISSUE: ir_valid=1. On pc_load: pc<=pc+1, go to FETCH.
- TARGET: imem_req=1, imem_addr=pc (operand byte). On accept, tgt=imem_data and zero_flag is sampled in that cycle.
  - Taken if JMP/GOTO, JZ with zero_flag=1, JNZ with zero_flag=0, or CALL with stack not full.
  - CALL taken: push pc+1.
  - Taken: pc<=tgt. Not taken: pc<=pc+1.
  - Go to FETCH.
- CALL on full stack: no push, no jump, pc<=pc+1, stack_err<=1.
- RETURN: stack not empty → pc<=pop. Stack empty → pc<=pc+1, stack_err<=1. Go to FETCH.
- ir_valid is never asserted for resolved opcodes.
- pc_load outside ISSUE is ignored.
- imem_valid while imem_req=0 is ignored.
- PC arithmetic is modulo 2^ADDR_W: 0xFF+1 = 0x00, including the operand address.
- stack_err clears only on reset.

## Timing
- Reset values: pc=RESET_PC, ir=0x00, ir_valid=0, imem_req=0, imem_addr=0, stack_err=0, stack pointer=0 (empty), state=IDLE.
- Reset assertion mid-handshake drops imem_req immediately (asynchronous); the pending read is abandoned.
- Zero-wait memory (imem_valid same cycle as request):
  - ALU opcode: FETCH 1 cycle, then ISSUE; ir_valid rises the cycle after accept.
  - Resolved jump: FETCH 1 + TARGET 1 cycle; the target opcode is requested in the 3rd cycle.
  - RET: FETCH 1 + RETURN 1 cycle.
- Wait states stretch FETCH/TARGET one cycle each; address and request stay held.
- pc_load in ISSUE: pc increments and imem_req rises on the next cycle.
- Push and pop never occur in the same cycle.

## Structure
- fetch_pkg: opcode constants (OP_JMP, OP_CALL, OP_RET, OP_GOTO, OP_JZ, OP_JNZ), state enum, ADDR_W default.
- Sub-module return_stack: synchronous LIFO of STACK_DEPTH×ADDR_W.
  - Ports: push, pop, din, dout (top of stack), full, empty.
  - Asynchronous active-low reset clears the pointer.

## Test plan
- Reset, mem[0]=0x01: imem_addr=0x00 with req in cycle 2; ir=0x01 and ir_valid=1 in cycle 3. pc_load pulse → pc=0x01, request at 0x01.
- mem[0x10]=0x81, mem[0x11]=0x40, pc=0x10: next request at 0x40; ir_valid stays 0 throughout.
- JZ 0x85,0x20 at 0x30: zero_flag=1 → pc=0x20; zero_flag=0 → pc=0x32.
- CALL 0x82,0x50 at 0x05, then RET at 0x50: stack holds 0x07; after RET, fetch at 0x07.
- Five nested CALLs with STACK_DEPTH=4: the fifth falls through to pc+2 and stack_err=1. RET with empty stack → pc+1, stack_err stays 1.
- 3-cycle imem_valid delay, with reset_n dropped mid-wait: imem_req goes 0 immediately; after release, fetch restarts at RESET_PC. Also check wrap: pc=0xFF with pc_load → request at 0x00.
